// File: rtl/id_exe_reg_if.sv
// rtl/id_exe_reg_if.sv - ID/EXE stage field bundle: decode-side inputs and EXE-side registered outputs
interface id_exe_reg_if #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int EXE_CMD_LEN  = 4
);
    logic                    branchEn_in, Is_Imm_in, ST_or_BNE_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [EXE_CMD_LEN-1:0]  EXE_CMD_in;
    logic [1:0]              Branch_command_in;
    logic [WORD_LEN-1:0]     pc_in, val1_in, val2_in, st_val_in;
    logic [REG_ADDR_LEN-1:0] src1_in, src2_in, dest_in;

    logic                    branchEn_out, Is_Imm_out, ST_or_BNE_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;
    logic [EXE_CMD_LEN-1:0]  EXE_CMD_out;
    logic [1:0]              Branch_command_out;
    logic [WORD_LEN-1:0]     pc_out, val1_out, val2_out, st_val_out;
    logic [REG_ADDR_LEN-1:0] src1_out, src2_out, dest_out;
    logic                    valid_out;

    modport master (
        output branchEn_in, Is_Imm_in, ST_or_BNE_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in,
               EXE_CMD_in, Branch_command_in, pc_in, val1_in, val2_in, st_val_in,
               src1_in, src2_in, dest_in,
        input  branchEn_out, Is_Imm_out, ST_or_BNE_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out,
               EXE_CMD_out, Branch_command_out, pc_out, val1_out, val2_out, st_val_out,
               src1_out, src2_out, dest_out, valid_out
    );

    modport slave (
        input  branchEn_in, Is_Imm_in, ST_or_BNE_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in,
               EXE_CMD_in, Branch_command_in, pc_in, val1_in, val2_in, st_val_in,
               src1_in, src2_in, dest_in,
        output branchEn_out, Is_Imm_out, ST_or_BNE_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out,
               EXE_CMD_out, Branch_command_out, pc_out, val1_out, val2_out, st_val_out,
               src1_out, src2_out, dest_out, valid_out
    );
endinterface

// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - ID/EXE pipeline register with flush, freeze, bubble insertion and saturating event counters
module id_exe_reg #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int EXE_CMD_LEN  = 4,
    parameter int CNT_LEN      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               hazard_detected,
    input  logic               cnt_clr,
    id_exe_reg_if.slave        bus,
    output logic [CNT_LEN-1:0] bubble_cnt,
    output logic [CNT_LEN-1:0] flush_cnt,
    output logic [CNT_LEN-1:0] instr_cnt
);
    typedef struct packed {
        logic                    branch_en;
        logic                    is_imm;
        logic                    st_or_bne;
        logic                    wb_en;
        logic                    mem_r_en;
        logic                    mem_w_en;
        logic [EXE_CMD_LEN-1:0]  exe_cmd;
        logic [1:0]              br_cmd;
        logic [WORD_LEN-1:0]     pc;
        logic [WORD_LEN-1:0]     val1;
        logic [WORD_LEN-1:0]     val2;
        logic [WORD_LEN-1:0]     st_val;
        logic [REG_ADDR_LEN-1:0] src1;
        logic [REG_ADDR_LEN-1:0] src2;
        logic [REG_ADDR_LEN-1:0] dest;
    } stage_t;

    stage_t             stage_q, stage_d, in_s;
    logic               valid_q, valid_d;
    logic [CNT_LEN-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_LEN-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_LEN-1:0] instr_cnt_q, instr_cnt_d;
    logic               bubble_ev, instr_ev;

    function automatic logic [CNT_LEN-1:0] sat_inc(input logic [CNT_LEN-1:0] c, input logic ev);
        return (ev && (c != '1)) ? c + CNT_LEN'(1) : c;
    endfunction

    always_comb begin
        in_s = '{branch_en: bus.branchEn_in, is_imm: bus.Is_Imm_in, st_or_bne: bus.ST_or_BNE_in,
                 wb_en: bus.WB_EN_in, mem_r_en: bus.MEM_R_EN_in, mem_w_en: bus.MEM_W_EN_in,
                 exe_cmd: bus.EXE_CMD_in, br_cmd: bus.Branch_command_in,
                 pc: bus.pc_in, val1: bus.val1_in, val2: bus.val2_in, st_val: bus.st_val_in,
                 src1: bus.src1_in, src2: bus.src2_in, dest: bus.dest_in};

        stage_d   = stage_q;
        valid_d   = valid_q;
        bubble_ev = 1'b0;
        instr_ev  = 1'b0;

        if (flush) begin
            stage_d = '0;
            valid_d = 1'b0;
        end else if (!freeze) begin
            stage_d = in_s;
            if (hazard_detected) begin
                // Bubble: data still loads, but every control bit is forced off.
                stage_d.branch_en = 1'b0;
                stage_d.is_imm    = 1'b0;
                stage_d.st_or_bne = 1'b0;
                stage_d.wb_en     = 1'b0;
                stage_d.mem_r_en  = 1'b0;
                stage_d.mem_w_en  = 1'b0;
                stage_d.exe_cmd   = '0;
                stage_d.br_cmd    = '0;
                valid_d   = 1'b0;
                bubble_ev = 1'b1;
            end else begin
                valid_d  = 1'b1;
                instr_ev = 1'b1;
            end
        end

        if (cnt_clr) begin
            bubble_cnt_d = '0;
            flush_cnt_d  = '0;
            instr_cnt_d  = '0;
        end else begin
            bubble_cnt_d = sat_inc(bubble_cnt_q, bubble_ev);
            flush_cnt_d  = sat_inc(flush_cnt_q, flush);
            instr_cnt_d  = sat_inc(instr_cnt_q, instr_ev);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q      <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
            instr_cnt_q  <= '0;
        end else begin
            stage_q      <= stage_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            instr_cnt_q  <= instr_cnt_d;
        end
    end

    assign bus.branchEn_out       = stage_q.branch_en;
    assign bus.Is_Imm_out         = stage_q.is_imm;
    assign bus.ST_or_BNE_out      = stage_q.st_or_bne;
    assign bus.WB_EN_out          = stage_q.wb_en;
    assign bus.MEM_R_EN_out       = stage_q.mem_r_en;
    assign bus.MEM_W_EN_out       = stage_q.mem_w_en;
    assign bus.EXE_CMD_out        = stage_q.exe_cmd;
    assign bus.Branch_command_out = stage_q.br_cmd;
    assign bus.pc_out             = stage_q.pc;
    assign bus.val1_out           = stage_q.val1;
    assign bus.val2_out           = stage_q.val2;
    assign bus.st_val_out         = stage_q.st_val;
    assign bus.src1_out           = stage_q.src1;
    assign bus.src2_out           = stage_q.src2;
    assign bus.dest_out           = stage_q.dest;
    assign bus.valid_out          = valid_q;
    assign bubble_cnt             = bubble_cnt_q;
    assign flush_cnt              = flush_cnt_q;
    assign instr_cnt              = instr_cnt_q;
endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - table-driven directed bench for id_exe_reg (3-bit counters to reach saturation)
module tb_id_exe_reg;
    logic       clk = 1'b0;
    logic       rst, freeze, flush, hazard_detected, cnt_clr;
    logic [2:0] bubble_cnt, flush_cnt, instr_cnt;

    id_exe_reg_if #(.WORD_LEN(32), .REG_ADDR_LEN(5), .EXE_CMD_LEN(4)) bus ();

    id_exe_reg #(.WORD_LEN(32), .REG_ADDR_LEN(5), .EXE_CMD_LEN(4), .CNT_LEN(3)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .hazard_detected(hazard_detected), .cnt_clr(cnt_clr), .bus(bus),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // ctrl packing: {branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN}
    // dmode: 0 = data fields expected zero, 1 = loaded from this row, 2 = held
    typedef struct {
        logic rst, flush, freeze, haz, clr;
        logic [5:0] ctrl; logic [3:0] cmd; logic [1:0] br;
        logic [31:0] pc, val1; logic [4:0] dest;
        logic [1:0] dmode;
        logic e_valid; logic [5:0] e_ctrl; logic [3:0] e_cmd; logic [1:0] e_br;
        logic [2:0] e_bub, e_fl, e_ins;
    } vec_t;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0010;

    vec_t         vecs[$];
    vec_t         v;
    logic [142:0] exp_data;
    int           n_cmp = 0;
    int           n_fail = 0;

    function automatic logic [142:0] derive(input logic [31:0] pc, input logic [31:0] val1, input logic [4:0] dest);
        return {pc, val1, ~val1, val1 ^ 32'hA5A5_0000, dest + 5'd1, dest + 5'd2, dest};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic apply_vec(input vec_t x, input int idx);
        rst = x.rst; flush = x.flush; freeze = x.freeze; hazard_detected = x.haz; cnt_clr = x.clr;
        {bus.branchEn_in, bus.Is_Imm_in, bus.ST_or_BNE_in, bus.WB_EN_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in} = x.ctrl;
        bus.EXE_CMD_in = x.cmd; bus.Branch_command_in = x.br;
        {bus.pc_in, bus.val1_in, bus.val2_in, bus.st_val_in, bus.src1_in, bus.src2_in, bus.dest_in} =
            (x.rst && x.ctrl == 6'h3F) ? {143{1'b1}} : derive(x.pc, x.val1, x.dest);
        @(posedge clk);
        #1;
        case (x.dmode)
            2'd0:    exp_data = '0;
            2'd1:    exp_data = derive(x.pc, x.val1, x.dest);
            default: ;
        endcase
        chk($sformatf("valid[%0d]", idx), 160'(bus.valid_out), 160'(x.e_valid));
        chk($sformatf("ctrl[%0d]", idx), 160'({bus.branchEn_out, bus.Is_Imm_out, bus.ST_or_BNE_out,
            bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out}), 160'(x.e_ctrl));
        chk($sformatf("exe_cmd[%0d]", idx), 160'(bus.EXE_CMD_out), 160'(x.e_cmd));
        chk($sformatf("br_cmd[%0d]", idx), 160'(bus.Branch_command_out), 160'(x.e_br));
        chk($sformatf("data[%0d]", idx), 160'({bus.pc_out, bus.val1_out, bus.val2_out, bus.st_val_out,
            bus.src1_out, bus.src2_out, bus.dest_out}), 160'(exp_data));
        chk($sformatf("bubble_cnt[%0d]", idx), 160'(bubble_cnt), 160'(x.e_bub));
        chk($sformatf("flush_cnt[%0d]", idx), 160'(flush_cnt), 160'(x.e_fl));
        chk($sformatf("instr_cnt[%0d]", idx), 160'(instr_cnt), 160'(x.e_ins));
    endtask

    initial begin
        exp_data = '0;
        //              rst   flush freeze haz   clr   ctrl       cmd    br     pc            val1          dest   dm    ev    ectrl      ecmd  ebr   bub   fl    ins
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,1'b1,6'h3F,     4'hF,  2'h3,  32'hFFFF_FFFF,32'hFFFF_FFFF,5'h1F,2'd0,1'b0,6'b000000,4'h0,2'h0,3'd0,3'd0,3'd0});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,1'b1,6'h3F,     4'hF,  2'h3,  32'hFFFF_FFFF,32'hFFFF_FFFF,5'h1F,2'd0,1'b0,6'b000000,4'h0,2'h0,3'd0,3'd0,3'd0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,6'b000100,ADD,   2'h0,  32'h4,        32'h10,       5'd5, 2'd1,1'b1,6'b000100,ADD, 2'h0,3'd0,3'd0,3'd1});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,6'b111110,SUB,   2'h1,  32'h8,        32'h20,       5'd6, 2'd1,1'b0,6'b000000,4'h0,2'h0,3'd1,3'd0,3'd1});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,6'b000100,SUB,   2'h0,  32'hC,        32'h30,       5'd7, 2'd1,1'b1,6'b000100,SUB, 2'h0,3'd1,3'd0,3'd2});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,6'b001001,ADD,   2'h0,  32'h10,       32'h40,       5'd8, 2'd0,1'b0,6'b000000,4'h0,2'h0,3'd1,3'd1,3'd2});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,6'b000100,4'h5,  2'h2,  32'h14,       32'h50,       5'd9, 2'd2,1'b0,6'b000000,4'h0,2'h0,3'd1,3'd1,3'd2});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,6'b100000,ADD,   2'h2,  32'h18,       32'h60,       5'd0, 2'd1,1'b1,6'b100000,ADD, 2'h2,3'd1,3'd1,3'd3});
        for (int k = 0; k < 3; k++)
            vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,6'b000110,ADD,2'h0,32'h1C,   32'h70,       5'd10,2'd2,1'b1,6'b100000,ADD, 2'h2,3'd1,3'd1,3'd3});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,6'b000110,ADD,   2'h0,  32'h1C,       32'h70,       5'd10,2'd1,1'b0,6'b000000,4'h0,2'h0,3'd2,3'd1,3'd3});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,6'b000100,4'h3,  2'h0,  32'h20,       32'h80,       5'd11,2'd0,1'b0,6'b000000,4'h0,2'h0,3'd2,3'd2,3'd3});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,6'b000100,4'h7,  2'h0,  32'h24,       32'h90,       5'd12,2'd1,1'b1,6'b000100,4'h7,2'h0,3'd0,3'd0,3'd0});

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Saturation: nine back-to-back loads from a cleared counter stop at 7.
        for (int i = 0; i < 9; i++) begin
            v = '{1'b0,1'b0,1'b0,1'b0,1'b0,6'b000101,4'h1,2'h0,32'(100 + i * 4),32'(i),5'(i),2'd1,
                  1'b1,6'b000101,4'h1,2'h0,3'd0,3'd0,3'((i + 1 > 7) ? 7 : i + 1)};
            apply_vec(v, 100 + i);
        end
        // Clear wins over a same-cycle increment; pipeline still loads.
        v = '{1'b0,1'b0,1'b0,1'b0,1'b1,6'b010100,4'h8,2'h0,32'h200,32'hDEAD,5'd20,2'd1,
              1'b1,6'b010100,4'h8,2'h0,3'd0,3'd0,3'd0};
        apply_vec(v, 200);

        // Mid-stream reset, then the first load after it is a normal load.
        v = '{1'b0,1'b0,1'b0,1'b0,1'b0,6'b000010,ADD,2'h0,32'h300,32'h1234,5'd3,2'd1,
              1'b1,6'b000010,ADD,2'h0,3'd0,3'd0,3'd1};
        apply_vec(v, 300);
        v = '{1'b1,1'b0,1'b0,1'b0,1'b1,6'b000100,SUB,2'h1,32'h304,32'h5678,5'd4,2'd0,
              1'b0,6'b000000,4'h0,2'h0,3'd0,3'd0,3'd0};
        apply_vec(v, 301);
        v = '{1'b0,1'b0,1'b0,1'b0,1'b0,6'b001001,SUB,2'h1,32'h308,32'h9ABC,5'd6,2'd1,
              1'b1,6'b001001,SUB,2'h1,3'd0,3'd0,3'd1};
        apply_vec(v, 302);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/id_exe_reg.md
# id_exe_reg

ID/EXE pipeline register of the five-stage MIPS pipeline with forwarding. It captures the decode-stage control word produced by the instruction controller, together with operands, PC and register addresses, and presents them to the EXE stage one cycle later. It performs bubble insertion on hazards, flush on taken branches and hold on freeze, and keeps saturating event counters for stall and flush analysis.

## Interface

Parameters:
- WORD_LEN, 32, data/PC width
- REG_ADDR_LEN, 5, register-file address width
- EXE_CMD_LEN, 4, ALU command width (matches `EXE_CMD_LEN)
- CNT_LEN, 16, width of each event counter

Ports:
- clk  in  1  rising-edge clock; the block uses this single clock
- rst  in  1  reset, synchronous and active-high
- freeze  in  1  hold all stage contents (memory wait)
- flush  in  1  branch taken in EXE; squash the instruction entering EXE next
- hazard_detected  in  1  load-use/data hazard from hazard unit; insert bubble
- cnt_clr  in  1  synchronous clear of all counters
- branchEn_in, Is_Imm_in, ST_or_BNE_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  control bits from controller
- EXE_CMD_in  in  EXE_CMD_LEN  ALU command
- Branch_command_in  in  2  branch condition
- pc_in, val1_in, val2_in, st_val_in  in  WORD_LEN  PC+4, operand 1, operand 2 / sign-extended imm, store data
- src1_in, src2_in, dest_in  in  REG_ADDR_LEN  source/destination register numbers
- *_out  out  same as matching *_in  registered copies of every field above
- valid_out  out  1  registered instruction is real (not bubble/flush/reset)
- bubble_cnt, flush_cnt, instr_cnt  out  CNT_LEN  saturating event counters

## Operation

- Per-cycle action priority, highest first: rst, flush, freeze, hazard_detected, normal load.
- rst: every output, including all counters, goes to 0.
- flush: all control outputs (branchEn, EXE_CMD, Branch_command, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN) go to 0. valid_out goes to 0. Data/address fields go to 0. flush_cnt increments. flush overrides freeze.
- freeze (no flush): all *_out and valid_out hold. No counter changes.
- hazard_detected (no flush, no freeze): full bubble. All control bits go to 0 regardless of the *_in values, including MEM_R_EN, branchEn, Is_Imm and ST_or_BNE, which the controller does not clear. valid_out goes to 0. Data fields load normally; this is harmless because control is zero. bubble_cnt increments.
- Normal: all fields load from *_in. valid_out goes to 1. instr_cnt increments.
- Counters saturate at 2^CNT_LEN-1 and do not wrap.
- cnt_clr zeroes all counters. It takes priority over increments in the same cycle. It does not affect pipeline fields. rst overrides it.
- Every outgoing write enable is gated by valid. Downstream sees WB_EN_out=MEM_W_EN_out=MEM_R_EN_out=0 whenever valid_out=0.

## Timing

- Latency: exactly 1 cycle from input to *_out on the next rising clk edge.
- All outputs are registers. There is no combinational path from any input to any output.
- flush is sampled on the same edge it is asserted. The bubble is visible in the cycle after.
- Simultaneous flush+hazard_detected: flush wins. Only flush_cnt increments.
- Simultaneous freeze+hazard_detected: hold. bubble_cnt does not increment. The hazard is re-evaluated after freeze drops.
- rst asserted mid-stream clears the stage on the next edge. The first load after rst deasserts is a normal load.

## Test plan

- Reset: rst=1 for 2 cycles with all *_in=1s. Then every output=0 and all counters=0.
- Normal load: ADD control (EXE_CMD_in=ADD code, WB_EN_in=1), dest_in=5, val1_in=0x10. Next cycle: outputs match, valid_out=1, instr_cnt=1.
- Hazard bubble: LD control (MEM_R_EN_in=1, WB_EN_in=1) with hazard_detected=1. Next cycle: MEM_R_EN_out=0, WB_EN_out=0, valid_out=0, bubble_cnt=1.
- Flush vs freeze: load instr A, then assert freeze=1 and flush=1 together. Next cycle: control zero, valid_out=0, flush_cnt=1. Then freeze=1 alone with new inputs: outputs unchanged.
- Saturation: CNT_LEN=3, 9 consecutive normal loads gives instr_cnt=7. Then cnt_clr=1 with a normal load in the same cycle gives instr_cnt=0.
- Freeze+hazard: both high for 3 cycles gives outputs held and bubble_cnt unchanged. Then freeze drops with hazard still high: one bubble, bubble_cnt+1.
